blink_scheduler: RTL and testbench
==================================

// Module: blink_scheduler
// PURPOSE
// Shares one blinking indicator light between NREQ requesters. Each requester
// asks for a burst of C blinks; a round-robin arbiter grants one request at a
// time and an FSM sequences the light through on/off phases and a trailing gap.
// Sits between status sources (UART, heartbeat, error flags) and the board LED.
// PARAMETERS
// NREQ        4   number of requesters (>=2)
// CNT_W       4   width of each blink-count field
// HALF_PERIOD 11  cycles light is on, and cycles it is off, per blink (>=1)
// GAP_CYCLES  22  dark cycles after a burst before next grant (>=1)
// PORTS
// clk        in   1           system clock, all logic on rising edge
// rst        in   1           asynchronous reset, active-high
// req_valid  in   NREQ        request i pending; hold until accepted
// req_count  in   NREQ*CNT_W  blink count for req i at [i*CNT_W +: CNT_W]
// req_ready  out  NREQ        one-hot accept strobe (combinational)
// light      out  1           shared LED drive, registered
// busy       out  1           1 whenever state != IDLE, registered
// owner      out  clog2(NREQ) index of current/last granted requester
// done       out  1           1-cycle pulse when a burst fully completes
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, light=0, busy=0, done=0, owner=0,
//   rr_ptr=0, timers/counters=0. Reset mid-burst aborts it; no done pulse.
// - States: IDLE, ON, OFF, GAP.
// - Arbitration in IDLE only: winner = first i with req_valid[i]=1 searching
//   rr_ptr, rr_ptr+1, ... mod NREQ. req_ready[winner]=1 that cycle, all other
//   bits 0; req_ready=0 in every non-IDLE state. Handshake = valid&ready.
// - On accept edge: owner<=winner, rr_ptr<=(winner+1) mod NREQ, remaining<=
//   req_count[winner]. Next state ON if count>=1, GAP if count==0.
// - ON: light=1 for exactly HALF_PERIOD cycles, then OFF.
// - OFF: light=0 for exactly HALF_PERIOD cycles; remaining decrements at end;
//   if new remaining>0 -> ON, else -> GAP.
// - GAP: light=0 for exactly GAP_CYCLES cycles, then IDLE.
// - done=1 in the first IDLE cycle after GAP only; arbitration may accept in
//   that same cycle (back-to-back bursts allowed).
// - Latency: accept at cycle T -> light=1 from T+1. Count C>=1 burst occupies
//   2*C*HALF_PERIOD+GAP_CYCLES cycles from T+1 to done; C=0 takes GAP_CYCLES.
// - Requester changing req_valid/req_count after accept has no effect on the
//   running burst; a still-asserted valid is a new request.
// - Light toggles only on phase boundaries; no glitches (output registered).
// - Phase timer width = clog2(max(HALF_PERIOD,GAP_CYCLES)); counts 0..N-1.
// TESTING
// - Req0 count=3, others idle -> ready[0] one cycle; light 11 hi/11 lo x3,
//   then 22 lo; done pulse at accept+89; owner=0.
// - All four valid, count=1, held -> grant order 0,1,2,3,0; each burst 44
//   cycles; no cycle with two ready bits set; busy low only one cycle between.
// - Req2 count=0 -> accepted, light stays 0, done after 22 GAP cycles.
// - Req1 count=15 (max) -> exactly 15 rising edges on light, then done.
// - Assert rst during 2nd ON phase -> light=0 and busy=0 same cycle, no done;
//   after release, pending req0 accepted with rr_ptr=0.
// - Req3 valid while req1 burst runs -> ready[3] only after req1 done; fairness:
//   req1 reasserting immediately is served after req3.

Source files
------------

// File: rtl/blink_scheduler.sv
// Shares one blinking LED between NREQ requesters: a round-robin arbiter picks
// one blink-count request at a time and an FSM plays it as on/off phases plus a gap.
module blink_scheduler #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned HALF_PERIOD = 11,
    parameter int unsigned GAP_CYCLES  = 22
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*CNT_W-1:0]     req_count,
    output logic [NREQ-1:0]           req_ready,
    output logic                      light,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      done
);

    localparam int unsigned OWN_W   = $clog2(NREQ);
    localparam int unsigned TMR_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(HALF_PERIOD - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] OFF  = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic [OWN_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [OWN_W-1:0] owner_nxt;
    logic             light_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [CNT_W-1:0] cnt_arr [NREQ];
    logic             found;
    logic [OWN_W-1:0] winner;
    logic [OWN_W-1:0] pos;

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        assign cnt_arr[i] = req_count[i*CNT_W +: CNT_W];
    end

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        pos    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = OWN_W'((32'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        remaining_nxt = remaining;
        rr_ptr_nxt    = rr_ptr;
        owner_nxt     = owner;
        req_ready     = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    owner_nxt         = winner;
                    rr_ptr_nxt        = (32'(winner) == NREQ - 1) ? '0 : winner + OWN_W'(1);
                    remaining_nxt     = cnt_arr[winner];
                    timer_nxt         = '0;
                    state_nxt         = (cnt_arr[winner] != '0) ? ON : GAP;
                end
            end
            ON: begin
                if (timer == ON_LAST) begin
                    timer_nxt = '0;
                    state_nxt = OFF;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            OFF: begin
                if (timer == ON_LAST) begin
                    timer_nxt     = '0;
                    remaining_nxt = remaining - CNT_W'(1);
                    state_nxt     = (remaining != CNT_W'(1)) ? ON : GAP;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase

        light_nxt = (state_nxt == ON);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state == GAP) && (state_nxt == IDLE);
    end

    // Outputs are decoded from the next state so they line up with it, glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            light     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            remaining <= remaining_nxt;
            rr_ptr    <= rr_ptr_nxt;
            owner     <= owner_nxt;
            light     <= light_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler: burst timing, round-robin order, zero/max
// counts, reset mid-burst and fairness against a reasserting requester.
module tb_blink_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_count;
    logic [3:0]  req_ready;
    logic        light;
    logic        busy;
    logic [1:0]  owner;
    logic        done;

    int passed = 0;
    int total  = 0;

    blink_scheduler #(
        .NREQ(4), .CNT_W(4), .HALF_PERIOD(11), .GAP_CYCLES(22)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_count(req_count),
        .req_ready(req_ready), .light(light), .busy(busy), .owner(owner), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        total++; if (light !== 1'b0) $display("FAIL reset_light got %0b expected 0", light); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %0b expected 0", done); else passed++;
        total++; if (owner !== 2'd0) $display("FAIL reset_owner got %0d expected 0", owner); else passed++;
        total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b expected 0000", req_ready); else passed++;
        step();
        rst = 1'b0;
        #1;
        step();
        total++; if (busy !== 1'b0) $display("FAIL idle_busy got %0b expected 0", busy); else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_r;
        int w;
        step();
        req_count = 16'h1111;
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            w = g % 4;
            exp_r = 4'(1 << w);
            total++; if (req_ready !== exp_r) $display("FAIL rr_grant g=%0d got %b expected %b", g, req_ready, exp_r); else passed++;
            for (int n = 1; n <= 45; n++) begin
                step();
                if (n == 1 && g == 4) begin
                    req_valid = 4'b0000;
                    #1;
                end
                if (n == 1) begin
                    total++; if (owner !== 2'(w)) $display("FAIL rr_owner g=%0d got %0d expected %0d", g, owner, w); else passed++;
                end
                if (n <= 44) begin
                    total++; if (req_ready !== 4'b0000) $display("FAIL rr_ready_busy g=%0d n=%0d got %b expected 0000", g, n, req_ready); else passed++;
                    total++; if (busy !== 1'b1) $display("FAIL rr_busy g=%0d n=%0d got %0b expected 1", g, n, busy); else passed++;
                    total++; if (light !== (n <= 11)) $display("FAIL rr_light g=%0d n=%0d got %0b expected %0b", g, n, light, n <= 11); else passed++;
                end else begin
                    total++; if (done !== 1'b1) $display("FAIL rr_done g=%0d got %0b expected 1", g, done); else passed++;
                    total++; if (busy !== 1'b0) $display("FAIL rr_gap_busy g=%0d got %0b expected 0", g, busy); else passed++;
                end
            end
        end
        total++; if (req_ready !== 4'b0000) $display("FAIL rr_final_ready got %b expected 0000", req_ready); else passed++;
    endtask

    task automatic test_single();
        logic exp_l;
        step();
        req_count = 16'h0003;
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b expected 0001", req_ready); else passed++;
        for (int n = 1; n <= 89; n++) begin
            step();
            if (n == 1) begin
                req_valid = 4'b0000;
                #1;
                total++; if (owner !== 2'd0) $display("FAIL single_owner got %0d expected 0", owner); else passed++;
            end
            exp_l = (n <= 66) && (((n - 1) % 22) < 11);
            total++; if (light !== exp_l) $display("FAIL single_light n=%0d got %0b expected %0b", n, light, exp_l); else passed++;
            total++; if (busy !== (n <= 88)) $display("FAIL single_busy n=%0d got %0b expected %0b", n, busy, n <= 88); else passed++;
            total++; if (done !== (n == 89)) $display("FAIL single_done n=%0d got %0b expected %0b", n, done, n == 89); else passed++;
            total++; if (req_ready !== 4'b0000) $display("FAIL single_ready_hold n=%0d got %b expected 0000", n, req_ready); else passed++;
        end
    endtask

    task automatic test_zero_count();
        step();
        req_count = 16'h0000;
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL zero_ready got %b expected 0100", req_ready); else passed++;
        for (int n = 1; n <= 23; n++) begin
            step();
            if (n == 1) begin
                req_valid = 4'b0000;
                #1;
                total++; if (owner !== 2'd2) $display("FAIL zero_owner got %0d expected 2", owner); else passed++;
            end
            total++; if (light !== 1'b0) $display("FAIL zero_light n=%0d got %0b expected 0", n, light); else passed++;
            total++; if (busy !== (n <= 22)) $display("FAIL zero_busy n=%0d got %0b expected %0b", n, busy, n <= 22); else passed++;
            total++; if (done !== (n == 23)) $display("FAIL zero_done n=%0d got %0b expected %0b", n, done, n == 23); else passed++;
        end
    endtask

    task automatic test_max_count();
        int   edges;
        logic prev;
        edges = 0;
        prev  = 1'b0;
        step();
        req_count = 16'h00F0;
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL max_ready got %b expected 0010", req_ready); else passed++;
        for (int n = 1; n <= 353; n++) begin
            step();
            if (n == 1) begin
                req_valid = 4'b0000;
                #1;
                total++; if (owner !== 2'd1) $display("FAIL max_owner got %0d expected 1", owner); else passed++;
            end
            if (light && !prev) edges++;
            prev = light;
            total++; if (done !== (n == 353)) $display("FAIL max_done n=%0d got %0b expected %0b", n, done, n == 353); else passed++;
        end
        total++; if (edges !== 15) $display("FAIL max_edges got %0d expected 15", edges); else passed++;
    endtask

    task automatic test_fairness();
        logic [3:0] start_r [3];
        logic [3:0] next_v  [3];
        logic [1:0] own_e   [3];
        start_r[0] = 4'b0010; start_r[1] = 4'b1000; start_r[2] = 4'b0010;
        next_v[0]  = 4'b1010; next_v[1]  = 4'b0010; next_v[2]  = 4'b0000;
        own_e[0]   = 2'd1;    own_e[1]   = 2'd3;    own_e[2]   = 2'd1;
        step();
        req_count = 16'h1010;
        req_valid = 4'b0010;
        #1;
        for (int b = 0; b < 3; b++) begin
            total++; if (req_ready !== start_r[b]) $display("FAIL fair_grant b=%0d got %b expected %b", b, req_ready, start_r[b]); else passed++;
            for (int n = 1; n <= 45; n++) begin
                step();
                if (n == 1) begin
                    req_valid = next_v[b];
                    #1;
                    total++; if (owner !== own_e[b]) $display("FAIL fair_owner b=%0d got %0d expected %0d", b, owner, own_e[b]); else passed++;
                end
                if (n <= 44) begin
                    total++; if (req_ready !== 4'b0000) $display("FAIL fair_blocked b=%0d n=%0d got %b expected 0000", b, n, req_ready); else passed++;
                end else begin
                    total++; if (done !== 1'b1) $display("FAIL fair_done b=%0d got %0b expected 1", b, done); else passed++;
                end
            end
        end
        total++; if (req_ready !== 4'b0000) $display("FAIL fair_final_ready got %b expected 0000", req_ready); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        step();
        req_count = 16'h0200;
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL rst_pre_ready got %b expected 0100", req_ready); else passed++;
        for (int n = 1; n <= 25; n++) begin
            step();
            if (n == 1) req_valid = 4'b0000;
        end
        total++; if (light !== 1'b1) $display("FAIL rst_pre_light got %0b expected 1", light); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got %0b expected 1", busy); else passed++;
        req_count = 16'h0001;
        req_valid = 4'b1011;
        rst = 1'b1;
        #1;
        total++; if (light !== 1'b0) $display("FAIL rst_light got %0b expected 0", light); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b expected 0", busy); else passed++;
        total++; if (owner !== 2'd0) $display("FAIL rst_owner got %0d expected 0", owner); else passed++;
        for (int n = 0; n < 2; n++) begin
            step();
            total++; if (done !== 1'b0) $display("FAIL rst_done n=%0d got %0b expected 0", n, done); else passed++;
            total++; if (light !== 1'b0) $display("FAIL rst_hold_light n=%0d got %0b expected 0", n, light); else passed++;
        end
        step();
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL rst_rrptr_ready got %b expected 0001", req_ready); else passed++;
        for (int n = 1; n <= 45; n++) begin
            step();
            if (n == 1) begin
                req_valid = 4'b0000;
                #1;
                total++; if (owner !== 2'd0) $display("FAIL rst_post_owner got %0d expected 0", owner); else passed++;
            end
            total++; if (light !== (n <= 11)) $display("FAIL rst_post_light n=%0d got %0b expected %0b", n, light, n <= 11); else passed++;
            total++; if (done !== (n == 45)) $display("FAIL rst_post_done n=%0d got %0b expected %0b", n, done, n == 45); else passed++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_count = 16'h0000;
        test_reset();
        test_round_robin();
        test_single();
        test_zero_count();
        test_max_count();
        test_fairness();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
